// File: rtl/nfu_pkg.sv
// Shared defaults and types for the NFU zero-skipping select generator.
// Latency: none (declarations only).
// Backpressure: n/a.
package nfu_pkg;

    // Default block parameters.
    localparam int NFU_BIT_WIDTH = 16;
    localparam int NFU_TN        = 16;
    localparam int NFU_D         = 2;
    localparam int NFU_SEL_WIDTH = 4;
    localparam int NFU_SKIP_W    = 16;

    // Window-entry field widths at the default parameters:
    // raw brick data, per-lane live mask, valid flag.
    localparam int NFU_ENT_DAT_W  = NFU_BIT_WIDTH * NFU_TN;
    localparam int NFU_ENT_LIVE_W = NFU_TN;
    localparam int NFU_ENT_VLD_W  = 1;

    // FILL: collecting a full lookahead window. DRAIN: last brick seen,
    // emit whatever remains without waiting for a full window.
    typedef enum logic {
        ST_FILL  = 1'b0,
        ST_DRAIN = 1'b1
    } nfu_state_e;

endpackage

// File: rtl/nfu_zero_sel_gen_if.sv
// Brick stream interface: input brick handshake plus emitted head/candidates/select.
// Latency: none (wires only).
// Backpressure: i_valid/o_ready on the input side, o_valid/i_ready on the output side.
// Ports: master drives the input brick stream and i_ready; slave (the generator)
// drives o_ready, o_valid, o_brick, o_cands, o_sel, o_skip_cnt.
interface nfu_zero_sel_gen_if
    import nfu_pkg::*;
#(
    parameter int BIT_WIDTH = NFU_BIT_WIDTH,
    parameter int Tn        = NFU_TN,
    parameter int D         = NFU_D,
    parameter int SEL_WIDTH = NFU_SEL_WIDTH
);
    logic                          i_valid;
    logic                          o_ready;
    logic [BIT_WIDTH*Tn-1:0]       i_brick;
    logic                          i_last;
    logic                          o_valid;
    logic                          i_ready;
    logic [BIT_WIDTH*Tn-1:0]       o_brick;
    logic [BIT_WIDTH*Tn*D-1:0]     o_cands;
    logic [SEL_WIDTH*Tn-1:0]       o_sel;
    logic [NFU_SKIP_W-1:0]         o_skip_cnt;

    modport master (
        output i_valid, i_brick, i_last, i_ready,
        input  o_ready, o_valid, o_brick, o_cands, o_sel, o_skip_cnt
    );

    modport slave (
        input  i_valid, i_brick, i_last, i_ready,
        output o_ready, o_valid, o_brick, o_cands, o_sel, o_skip_cnt
    );
endinterface

// File: rtl/nfu_lane_sel_pick.sv
// Per-lane priority pick: head lane if live, else nearest live candidate lane.
// Latency: combinational.
// Backpressure: none.
// Ports: headLive (head lane live), candLive[d-1] (candidate d valid and lane live),
// sel (0 = head, d = candidate d; 0 when nothing is live).
module nfu_lane_sel_pick
    import nfu_pkg::*;
#(
    parameter int D         = NFU_D,
    parameter int SEL_WIDTH = NFU_SEL_WIDTH
) (
    input  logic                 headLive,
    input  logic [D-1:0]         candLive,
    output logic [SEL_WIDTH-1:0] sel
);

    always_comb begin
        sel = '0;
        if (!headLive) begin
            // Walk from the farthest candidate down so the nearest live one wins.
            for (int d = D; d >= 1; d--) begin
                if (candLive[d-1]) begin
                    sel = SEL_WIDTH'(d);
                end
            end
        end
    end

endmodule

// File: rtl/nfu_zero_sel_gen.sv
// Zero-skipping select generator: head brick plus D lookahead bricks, per-lane selects.
// Latency: head emitted once D later bricks are held (or next cycle in drain).
// Backpressure: o_ready drops when window is full and not firing, and during drain.
// Ports: clk, rst_n (async active-low), io (slave side of nfu_zero_sel_gen_if).
module nfu_zero_sel_gen
    import nfu_pkg::*;
#(
    parameter int BIT_WIDTH = NFU_BIT_WIDTH,
    parameter int Tn        = NFU_TN,
    parameter int D         = NFU_D,
    parameter int SEL_WIDTH = NFU_SEL_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    nfu_zero_sel_gen_if.slave    io
);

    localparam int DATW = BIT_WIDTH * Tn;

    // Window entry 0 is the head, entries 1..D the candidates, nearest first.
    logic [D:0]                  winVld,  vldN;
    logic [D:0][Tn-1:0]          winLive, liveN;
    logic [D:0][DATW-1:0]        winDat,  datN;
    nfu_state_e                  state,   stateN;
    logic [NFU_SKIP_W-1:0]       skipCnt;

    logic                        drainMode;
    logic                        full;
    logic                        fire;
    logic                        accept;
    logic                        dropHead;
    logic                        placed;
    logic [Tn-1:0]               inLive;
    logic [SEL_WIDTH-1:0]        laneSel [Tn];

    assign drainMode = (state == ST_DRAIN);
    assign full      = &winVld;

    assign io.o_valid = winVld[0] && (full || drainMode);
    assign fire       = io.o_valid && io.i_ready;
    // Gated by rst_n so the input side reads not-ready for the whole reset.
    assign io.o_ready = rst_n && !drainMode && (!full || fire);
    assign accept     = io.i_valid && io.o_ready;

    assign io.o_brick    = winDat[0];
    assign io.o_skip_cnt = skipCnt;

    always_comb begin
        io.o_cands = '0;
        for (int d = 1; d <= D; d++) begin
            io.o_cands[(d-1)*DATW +: DATW] = winVld[d] ? winDat[d] : '0;
        end
    end

    always_comb begin
        inLive = '0;
        for (int k = 0; k < Tn; k++) begin
            inLive[k] = |io.i_brick[k*BIT_WIDTH +: BIT_WIDTH];
        end
    end

    for (genvar k = 0; k < Tn; k++) begin : g_lane
        logic [D-1:0] candLive;

        always_comb begin
            candLive = '0;
            for (int d = 1; d <= D; d++) begin
                candLive[d-1] = winVld[d] & winLive[d][k];
            end
        end

        nfu_lane_sel_pick #(
            .D         (D),
            .SEL_WIDTH (SEL_WIDTH)
        ) u_pick (
            .headLive (winVld[0] & winLive[0][k]),
            .candLive (candLive),
            .sel      (laneSel[k])
        );
    end

    always_comb begin
        io.o_sel = '0;
        for (int k = 0; k < Tn; k++) begin
            io.o_sel[k*SEL_WIDTH +: SEL_WIDTH] = laneSel[k];
        end
    end

    // Next window: consume selected candidate lanes, shift out the head, drop a
    // now-dead head (at most one), then append the accepted brick.
    always_comb begin
        vldN     = winVld;
        liveN    = winLive;
        datN     = winDat;
        stateN   = state;
        dropHead = 1'b0;
        placed   = 1'b0;

        if (fire) begin
            for (int d = 1; d <= D; d++) begin
                for (int k = 0; k < Tn; k++) begin
                    if (laneSel[k] == SEL_WIDTH'(d)) begin
                        liveN[d][k] = 1'b0;
                    end
                end
            end
            // Pass 0 always retires the head; pass 1 only drops a dead new head.
            for (int pass = 0; pass < 2; pass++) begin
                if (pass == 0 || (vldN[0] && liveN[0] == '0)) begin
                    if (pass == 1) begin
                        dropHead = 1'b1;
                    end
                    for (int j = 0; j < D; j++) begin
                        vldN[j]  = vldN[j+1];
                        liveN[j] = liveN[j+1];
                        datN[j]  = datN[j+1];
                    end
                    vldN[D]  = 1'b0;
                    liveN[D] = '0;
                    datN[D]  = '0;
                end
            end
        end

        if (accept) begin
            // Valid entries are always contiguous from the head.
            for (int j = 0; j <= D; j++) begin
                if (!vldN[j] && !placed) begin
                    placed   = 1'b1;
                    vldN[j]  = 1'b1;
                    liveN[j] = inLive;
                    datN[j]  = io.i_brick;
                end
            end
        end

        case (state)
            ST_FILL:  if (accept && io.i_last) stateN = ST_DRAIN;
            ST_DRAIN: if (vldN == '0)          stateN = ST_FILL;
            default:                           stateN = ST_FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            winVld  <= '0;
            winLive <= '0;
            winDat  <= '0;
            state   <= ST_FILL;
            skipCnt <= '0;
        end else begin
            winVld  <= vldN;
            winLive <= liveN;
            winDat  <= datN;
            state   <= stateN;
            if (dropHead) begin
                skipCnt <= skipCnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_nfu_zero_sel_gen.sv
// Bench for nfu_zero_sel_gen: stream-level reference model feeds a scoreboard queue.
// Latency: n/a.
// Backpressure: i_ready either forced or randomised per cycle.
module tb_nfu_zero_sel_gen;
    import nfu_pkg::*;

    localparam int BW   = 16;
    localparam int TN   = 16;
    localparam int D    = 2;
    localparam int SW   = 4;
    localparam int DATW = BW * TN;
    localparam int CW   = DATW * D;

    typedef struct {
        logic [DATW-1:0]  brick;
        logic [CW-1:0]    cands;
        logic [SW*TN-1:0] sel;
        logic [15:0]      skip;
    } exp_t;

    logic clk;
    logic rst_n;
    logic rdyRand;
    logic rdyForce;

    int   nTests = 0;
    int   nFail  = 0;
    logic [15:0]     expSkip = '0;
    exp_t            sbQ [$];
    logic [DATW-1:0] sDat [16];

    nfu_zero_sel_gen_if #(.BIT_WIDTH(BW), .Tn(TN), .D(D), .SEL_WIDTH(SW)) io ();

    nfu_zero_sel_gen #(.BIT_WIDTH(BW), .Tn(TN), .D(D), .SEL_WIDTH(SW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (io)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [511:0] got, input logic [511:0] exp);
        nTests++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Single driver for i_ready: random when rdyRand, else the forced level.
    initial begin
        io.i_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            io.i_ready = rdyRand ? ($urandom_range(0, 3) != 0) : rdyForce;
        end
    end

    // Output monitor: every fire pops one expected emission.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && io.o_valid && io.i_ready) begin
                checkVal("sb_has_entry", sbQ.size() != 0, 1'b1);
                if (sbQ.size() != 0) begin
                    e = sbQ.pop_front();
                    checkVal("o_brick",    io.o_brick,    e.brick);
                    checkVal("o_cands",    io.o_cands,    e.cands);
                    checkVal("o_sel",      io.o_sel,      e.sel);
                    checkVal("o_skip_cnt", io.o_skip_cnt, e.skip);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [DATW-1:0] mkBrick(input logic [15:0] val, input logic [TN-1:0] nz);
        logic [DATW-1:0] b;
        b = '0;
        for (int k = 0; k < TN; k++) begin
            if (nz[k]) b[k*BW +: BW] = val + 16'(k);
        end
        return b;
    endfunction

    // Stream-level reference: emissions depend only on brick order, not timing.
    task automatic buildExp(input int n);
        logic [TN-1:0] lv [16];
        exp_t e;
        int   h;
        logic found;
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < TN; k++) lv[i][k] = (sDat[i][k*BW +: BW] != 0);
        end
        h = 0;
        while (h < n) begin
            e.brick = sDat[h];
            e.cands = '0;
            e.sel   = '0;
            e.skip  = expSkip;
            for (int d = 1; d <= D; d++) begin
                if (h + d < n) e.cands[(d-1)*DATW +: DATW] = sDat[h+d];
            end
            for (int k = 0; k < TN; k++) begin
                if (!lv[h][k]) begin
                    found = 1'b0;
                    for (int d = 1; d <= D; d++) begin
                        if (!found && h + d < n && lv[h+d][k]) begin
                            found = 1'b1;
                            e.sel[k*SW +: SW] = SW'(d);
                            lv[h+d][k] = 1'b0;
                        end
                    end
                end
            end
            sbQ.push_back(e);
            h++;
            if (h < n && lv[h] == '0) begin
                expSkip = expSkip + 16'd1;
                h++;
            end
        end
    endtask

    // Call at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic sendBrick(input logic [DATW-1:0] b, input logic last);
        int n = 0;
        io.i_valid = 1'b1;
        io.i_brick = b;
        io.i_last  = last;
        @(negedge clk);
        while (!io.o_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        checkVal("accept_in_time", n < 300, 1'b1);
        @(posedge clk);
        #1;
        io.i_valid = 1'b0;
        io.i_last  = 1'b0;
        io.i_brick = '0;
    endtask

    task automatic waitDrain();
        int n = 0;
        while (sbQ.size() != 0 && n < 1000) begin
            @(posedge clk);
            n++;
        end
        checkVal("drain_in_time", sbQ.size() == 0, 1'b1);
        @(posedge clk);
        #1;
    endtask

    task automatic driveStream(input int n);
        for (int i = 0; i < n; i++) sendBrick(sDat[i], i == n - 1);
        waitDrain();
    endtask

    initial begin
        rst_n      = 1'b0;
        rdyRand    = 1'b0;
        rdyForce   = 1'b1;
        io.i_valid = 1'b0;
        io.i_brick = '0;
        io.i_last  = 1'b0;

        // Reset state.
        #12;
        checkVal("rst_o_valid", io.o_valid, 1'b0);
        checkVal("rst_o_ready", io.o_ready, 1'b0);
        checkVal("rst_skip",    io.o_skip_cnt, 16'd0);
        #10 rst_n = 1'b1;
        @(negedge clk);
        checkVal("post_rst_o_ready", io.o_ready, 1'b1);
        @(posedge clk);
        #1;

        // Four dense bricks: no skipping, o_valid first after the third accept.
        for (int i = 0; i < 4; i++) sDat[i] = mkBrick(16'h0100 * 16'(i + 1), '1);
        buildExp(4);
        sendBrick(sDat[0], 1'b0);
        @(negedge clk) checkVal("vld_after_acc1", io.o_valid, 1'b0);
        @(posedge clk) #1;
        sendBrick(sDat[1], 1'b0);
        @(negedge clk) checkVal("vld_after_acc2", io.o_valid, 1'b0);
        @(posedge clk) #1;
        sendBrick(sDat[2], 1'b0);
        @(negedge clk) checkVal("vld_after_acc3", io.o_valid, 1'b1);
        @(posedge clk) #1;
        sendBrick(sDat[3], 1'b1);
        waitDrain();
        checkVal("dense_skip", io.o_skip_cnt, 16'd0);

        // Head lane 3 empty, candidate 1 lane 3 = 5; later bricks keep lane 3 empty.
        sDat[0] = mkBrick(16'h0010, ~(16'h0001 << 3));
        sDat[1] = mkBrick(16'h0020, '1);
        sDat[1][3*BW +: BW] = 16'd5;
        sDat[2] = mkBrick(16'h0030, ~(16'h0001 << 3));
        sDat[3] = mkBrick(16'h0040, ~(16'h0001 << 3));
        buildExp(4);
        driveStream(4);

        // B1 only has lanes 0/1, both borrowed by B0: B1 gets dropped.
        sDat[0] = mkBrick(16'h0300, 16'hFFFC);
        sDat[1] = mkBrick(16'h0400, 16'h0003);
        sDat[2] = mkBrick(16'h0500, '1);
        sDat[3] = mkBrick(16'h0600, '1);
        buildExp(4);
        driveStream(4);
        checkVal("drop_skip_cnt", io.o_skip_cnt, expSkip);

        // Two-brick stream ending in last: drain, ready low until empty.
        sDat[0] = mkBrick(16'h0700, 16'h00FF);
        sDat[1] = mkBrick(16'h0800, 16'hFF00);
        buildExp(2);
        sendBrick(sDat[0], 1'b0);
        sendBrick(sDat[1], 1'b1);
        @(negedge clk) checkVal("drain_o_ready", io.o_ready, 1'b0);
        @(posedge clk) #1;
        waitDrain();
        checkVal("drain_exit_o_ready", io.o_ready, 1'b1);

        // Downstream stall with full window: outputs hold, ready low.
        rdyForce = 1'b0;
        @(posedge clk) #1;
        sDat[0] = mkBrick(16'h0900, 16'hFFF0);
        sDat[1] = mkBrick(16'h0A00, 16'hFF0F);
        sDat[2] = mkBrick(16'h0B00, '1);
        sDat[3] = mkBrick(16'h0C00, '1);
        buildExp(4);
        for (int i = 0; i < 3; i++) sendBrick(sDat[i], 1'b0);
        io.i_valid = 1'b1;
        io.i_brick = sDat[3];
        io.i_last  = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checkVal("stall_o_valid", io.o_valid, 1'b1);
            checkVal("stall_o_ready", io.o_ready, 1'b0);
            checkVal("stall_o_brick", io.o_brick, sbQ[0].brick);
            checkVal("stall_o_cands", io.o_cands, sbQ[0].cands);
            checkVal("stall_o_sel",   io.o_sel,   sbQ[0].sel);
        end
        rdyForce = 1'b1;
        @(posedge clk) #1;
        sendBrick(sDat[3], 1'b1);
        waitDrain();

        // Mid-stream reset with a full, stalled window.
        rdyForce = 1'b0;
        @(posedge clk) #1;
        for (int i = 0; i < 3; i++) sendBrick(mkBrick(16'h0D00 + 16'(i), '1), 1'b0);
        @(negedge clk) checkVal("pre_rst_o_valid", io.o_valid, 1'b1);
        checkVal("pre_rst_skip", io.o_skip_cnt, expSkip);
        #2 rst_n = 1'b0;
        #1;
        checkVal("mid_rst_o_valid", io.o_valid, 1'b0);
        checkVal("mid_rst_o_ready", io.o_ready, 1'b0);
        checkVal("mid_rst_skip",    io.o_skip_cnt, 16'd0);
        sbQ.delete();
        expSkip  = '0;
        rdyForce = 1'b1;
        @(posedge clk) #3 rst_n = 1'b1;
        @(negedge clk);
        checkVal("rel_o_ready", io.o_ready, 1'b1);
        checkVal("rel_o_valid", io.o_valid, 1'b0);
        @(posedge clk) #1;
        sDat[0] = mkBrick(16'h0E00, 16'h0F0F);
        buildExp(1);
        driveStream(1);

        // Random sparse streams under random downstream backpressure.
        rdyRand = 1'b1;
        for (int s = 0; s < 10; s++) begin
            int n;
            n = $urandom_range(1, 8);
            for (int i = 0; i < n; i++) begin
                sDat[i] = '0;
                if ($urandom_range(0, 4) != 0) begin
                    for (int k = 0; k < TN; k++) begin
                        if ($urandom_range(0, 2) == 0) sDat[i][k*BW +: BW] = 16'($urandom_range(1, 65535));
                    end
                end
            end
            buildExp(n);
            driveStream(n);
        end
        checkVal("final_skip", io.o_skip_cnt, expSkip);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule

// File: doc/nfu_zero_sel_gen.md
NFU_ZERO_SEL_GEN -- requirements
Module: nfu_zero_sel_gen

Interface
REQ-001 SHALL have parameter BIT_WIDTH, default 16, neuron value width.
REQ-002 SHALL have parameter Tn, default 16, lanes per brick.
REQ-003 SHALL have parameter D, default 2, lookahead depth (candidate bricks).
REQ-004 SHALL have parameter SEL_WIDTH, default 4, select code width; D < 2^SEL_WIDTH.
REQ-005 SHALL provide: clk  in  1  single clock; all state updates on rising edge.
REQ-006 SHALL provide: rst_n  in  1  reset, asynchronous, active-low.
REQ-007 SHALL provide: i_valid  in  1  input brick valid.
REQ-008 SHALL provide: o_ready  out  1  input brick accepted when i_valid & o_ready.
REQ-009 SHALL provide: i_brick  in  BIT_WIDTH*Tn  NBin brick; lane k at bits [k*BIT_WIDTH +: BIT_WIDTH].
REQ-010 SHALL provide: i_last  in  1  final brick of stream; qualified by i_valid.
REQ-011 SHALL provide: o_valid  out  1  output set valid.
REQ-012 SHALL provide: i_ready  in  1  downstream accepts when o_valid & i_ready.
REQ-013 SHALL provide: o_brick  out  BIT_WIDTH*Tn  head brick raw data.
REQ-014 SHALL provide: o_cands  out  BIT_WIDTH*Tn*D  candidate bricks; candidate d (1..D) at slice d-1, nearest lowest; invalid slots zero.
REQ-015 SHALL provide: o_sel  out  SEL_WIDTH*Tn  per-lane select; 0 = head lane, d = same lane of candidate d.
REQ-016 SHALL provide: o_skip_cnt  out  16  count of bricks dropped as fully consumed; wraps at 2^16.

Function
REQ-017 SHALL hold a window of D+1 entries (head + D candidates), each with data, valid bit, and Tn-bit live mask (lane nonzero and not consumed); live mask set from i_brick at accept.
REQ-018 SHALL accept input (o_ready=1) when window not full or output fires same cycle, and not in drain mode.
REQ-019 SHALL assert o_valid when head valid and (all D+1 entries valid or drain mode).
REQ-020 SHALL compute o_sel combinationally per lane: head live -> 0; else lowest d with candidate d valid and lane live -> d; else 0.
REQ-021 On output fire SHALL clear live bits of candidate lanes selected, then shift window by one.
REQ-022 After the shift, if new head is valid with all-zero live mask, SHALL drop it too (shift by two total, at most one drop per cycle) and increment o_skip_cnt.
REQ-023 Simultaneous accept and fire SHALL both occur; new brick enters first free slot after shift(s).
REQ-024 Accepting a brick with i_last=1 SHALL enter drain mode; drain emits without full window; drain exits when window empty; o_ready=0 during drain.
REQ-025 Latency: brick emitted earliest the cycle after D later bricks accepted, or one cycle after acceptance in drain.
REQ-026 o_brick/o_cands/o_sel SHALL be stable while o_valid=1 and i_ready=0.

Reset
REQ-027 rst_n low SHALL asynchronously clear all valid bits, live masks, data, drain mode, o_skip_cnt; outputs o_valid=0, o_ready=0 during reset, o_ready=1 first cycle after release; mid-stream reset discards window.

Structure
REQ-028 BIT_WIDTH, Tn, D, SEL_WIDTH defaults and window-entry field widths SHALL live in shared package nfu_pkg.
REQ-029 Per-lane priority select SHALL be one sub-module nfu_lane_sel_pick, instantiated Tn times.

Verification
REQ-030 4 nonzero bricks, D=2, i_ready=1 -> all o_sel=0, first o_valid after 3rd accept, o_skip_cnt=0.
REQ-031 Head lane 3 =0, cand1 lane 3 =5 -> o_sel lane3=1; cand1 later emitted with lane3 sel=0 and live cleared so not reused.
REQ-032 Brick B1 whose only nonzero lanes all consumed by B0 -> B1 dropped, o_skip_cnt=1, next emitted brick is B2.
REQ-033 Stream of 2 bricks, 2nd with i_last -> both emitted, o_ready=0 until window empty, then 1.
REQ-034 i_ready held 0 for 5 cycles with o_valid=1 -> outputs unchanged, o_ready=0 once full.
REQ-035 rst_n pulsed low mid-stream -> o_valid=0 immediately, o_skip_cnt=0, window empty after release.
